// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional build macro: FETCH_CYCLE_CT_EN (cycle counter).
package fetch_pkg;

  localparam int PW     = 10;
  localparam int IW     = 9;
  localparam int LUT_AW = 4;

  typedef enum logic [1:0] {
    PRIME,
    RUN,
    HALTED
  } fetch_state_t;

  localparam logic [IW-1:0] HALT_OP = 9'h1FF;

  // Absolute jump/branch targets, indexed by instruction[3:0].
  localparam logic [PW-1:0] TARGET_LUT [16] = '{
    10'h012, 10'h005, 10'h040, 10'h007,
    10'h080, 10'h0A0, 10'h0C0, 10'h0E0,
    10'h100, 10'h120, 10'h140, 10'h160,
    10'h180, 10'h1A0, 10'h1C0, 10'h3FF
  };

  function automatic logic [PW-1:0] pc_inc(
    input logic [PW-1:0] pc
  );
    return pc + PW'(1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: ROM port, Ctrl handshake and status.
// master = fetch_unit side, slave = ROM/Ctrl side.
interface fetch_if;
  import fetch_pkg::*;

  logic [PW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic [IW-1:0] inst_out;
  logic          inst_valid;
  logic          inst_ready;
  logic          jump_en;
  logic          branch_en;
  logic          alu_zero;
  logic [PW-1:0] PC;
  logic          halt;
  logic [15:0]   cycle_ct;

  modport master (
    output rom_addr,
    input  rom_data,
    output inst_out,
    output inst_valid,
    input  inst_ready,
    input  jump_en,
    input  branch_en,
    input  alu_zero,
    output PC,
    output halt,
    output cycle_ct
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  inst_out,
    input  inst_valid,
    output inst_ready,
    output jump_en,
    output branch_en,
    output alu_zero,
    input  PC,
    input  halt,
    input  cycle_ct
  );

endinterface

// File: rtl/branch_lut.sv
// Combinational jump/branch target lookup.
module branch_lut
  import fetch_pkg::*;
(
  input  logic [LUT_AW-1:0] idx,
  output logic [PW-1:0]     target
);

  assign target = TARGET_LUT[idx];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, InstROM drive, redirect, HALT.
// FETCH_CYCLE_CT_EN enables the executed-cycle counter.
module fetch_unit
  import fetch_pkg::*;
(
  input logic    CLK,
  input logic    reset,
  fetch_if.master bus
);

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_d;
  logic [PW-1:0] tgt;
  logic          consume;
  logic          is_halt;
  logic          redirect;

  branch_lut u_lut (
    .idx    (bus.inst_out[LUT_AW-1:0]),
    .target (tgt)
  );

  assign consume  = bus.inst_valid
                  & bus.inst_ready;
  assign is_halt  = (bus.inst_out == HALT_OP);
  assign redirect = bus.jump_en
                  | (bus.branch_en
                     & bus.alu_zero);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      PRIME: begin
        state_d = RUN;
        pc_d    = '0;
      end
      RUN: begin
        if (!consume) begin
          pc_d = pc_q;
        end else if (is_halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          pc_d = tgt;
        end else begin
          pc_d = pc_inc(pc_q);
        end
      end
      HALTED: begin
        pc_d = pc_q;
      end
      default: begin
        state_d = PRIME;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= PRIME;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Addressing the ROM with pc_next keeps its registered
  // output aligned with pc_q, so a stall simply re-reads.
  assign bus.rom_addr   = reset ? '0 : pc_d;
  assign bus.inst_out   = bus.rom_data;
  assign bus.inst_valid = (state_q == RUN);
  assign bus.PC         = pc_q;
  assign bus.halt       = (state_q == HALTED);

`ifdef FETCH_CYCLE_CT_EN
  logic [15:0] ct_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ct_q <= '0;
    end else if (state_q != HALTED
                 && ct_q != 16'hFFFF) begin
      ct_q <= ct_q + 16'd1;
    end
  end

  assign bus.cycle_ct = ct_q;
`else
  assign bus.cycle_ct = 16'h0000;
`endif

endmodule
